// File: rtl/ika2151_timer_ctrl.sv
// Timer-control register stage: CPU write capture, 64-tick busy window, timer register commit.
// Optional CSM key-on generation is built when IKA2151_TIMER_CTRL_CSM_EN is defined.
module ika2151_timer_ctrl (
    input  logic       i_EMUCLK,
    input  logic       i_MRST_n,
    input  logic       i_phi1_PCEN_n,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CYCLE_31,
    input  logic       i_CS_n,
    input  logic       i_WR_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    input  logic       i_TIMERA_FLAG,
    input  logic       i_TIMERB_FLAG,
    input  logic       i_TIMERA_OVFL,
    output logic [7:0] o_CLKA1,
    output logic [1:0] o_CLKA2,
    output logic [7:0] o_CLKB,
    output logic       o_TIMERA_RUN,
    output logic       o_TIMERB_RUN,
    output logic       o_TIMERA_IRQ_EN,
    output logic       o_TIMERB_IRQ_EN,
    output logic       o_TIMERA_FRST,
    output logic       o_TIMERB_FRST,
    output logic       o_CSM_KEYON,
    output logic       o_BUSY,
    output logic [7:0] o_STATUS
);

    logic       tick_s, strobe_s, wr_s, data_wr_s, commit_s;
    logic       strb_q, strb_d;
    logic [7:0] addr_q, addr_d, data_q, data_d;
    logic       pending_q, pending_d, busy_q, busy_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] clka1_q, clka1_d, clkb_q, clkb_d;
    logic [1:0] clka2_q, clka2_d;
    logic       runa_q, runa_d, runb_q, runb_d, irqa_q, irqa_d, irqb_q, irqb_d;
    logic       frsta_q, frsta_d, frstb_q, frstb_d, csm_q, csm_d;

    assign tick_s    = ~i_phi1_PCEN_n;
    assign strobe_s  = i_CS_n | i_WR_n;
    assign wr_s      = strb_q & ~strobe_s;
    assign data_wr_s = wr_s & i_A0 & ~busy_q;
    assign commit_s  = tick_s & i_CYCLE_31 & pending_q;

    // Next-state logic for bus capture, busy window and register commit
    always_comb begin
        strb_d    = strobe_s;
        addr_d    = addr_q;
        data_d    = data_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        clka1_d   = clka1_q;
        clka2_d   = clka2_q;
        clkb_d    = clkb_q;
        runa_d    = runa_q;
        runb_d    = runb_q;
        irqa_d    = irqa_q;
        irqb_d    = irqb_q;
        frsta_d   = frsta_q;
        frstb_d   = frstb_q;
        csm_d     = csm_q;

        if (wr_s && !i_A0) begin
            addr_d = i_D;
        end else begin
            addr_d = addr_q;
        end

        // A data write that opens the busy window swallows a coincident tick
        if (data_wr_s) begin
            data_d    = i_D;
            pending_d = 1'b1;
            busy_d    = 1'b1;
            cnt_d     = 6'd0;
        end else if (busy_q && tick_s) begin
            if (cnt_q == 6'd63) begin
                busy_d = 1'b0;
                cnt_d  = 6'd0;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (tick_s) begin
            frsta_d = 1'b0;
            frstb_d = 1'b0;
        end else begin
            frsta_d = frsta_q;
        end

        if (commit_s) begin
            pending_d = 1'b0;
            case (addr_q)
                8'h10: clka1_d = data_q;
                8'h11: clka2_d = data_q[1:0];
                8'h12: clkb_d  = data_q;
                8'h14: begin
                    csm_d   = data_q[7];
                    frstb_d = data_q[5];
                    frsta_d = data_q[4];
                    irqb_d  = data_q[3];
                    irqa_d  = data_q[2];
                    runb_d  = data_q[1];
                    runa_d  = data_q[0];
                end
                default: pending_d = 1'b0;
            endcase
        end else begin
            pending_d = pending_d;
        end
    end

    // State registers
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            strb_q    <= 1'b0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= 6'd0;
            clka1_q   <= 8'h00;
            clka2_q   <= 2'b00;
            clkb_q    <= 8'h00;
            runa_q    <= 1'b0;
            runb_q    <= 1'b0;
            irqa_q    <= 1'b0;
            irqb_q    <= 1'b0;
            frsta_q   <= 1'b0;
            frstb_q   <= 1'b0;
            csm_q     <= 1'b0;
        end else begin
            strb_q    <= strb_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            clka1_q   <= clka1_d;
            clka2_q   <= clka2_d;
            clkb_q    <= clkb_d;
            runa_q    <= runa_d;
            runb_q    <= runb_d;
            irqa_q    <= irqa_d;
            irqb_q    <= irqb_d;
            frsta_q   <= frsta_d;
            frstb_q   <= frstb_d;
            csm_q     <= csm_d;
        end
    end

`ifdef IKA2151_TIMER_CTRL_CSM_EN
    logic       csm_req_q, csm_req_d, keyon_q, keyon_d;
    logic [4:0] kcnt_q, kcnt_d;
    logic       unused_s;

    assign unused_s = &{1'b0, i_phi1_NCEN_n};

    // Key-on window: armed by overflow, opened at the next sample-cycle end, 32 ticks long
    always_comb begin
        csm_req_d = csm_req_q;
        keyon_d   = keyon_q;
        kcnt_d    = kcnt_q;
        if (tick_s) begin
            if (keyon_q) begin
                if (kcnt_q == 5'd31) begin
                    keyon_d = 1'b0;
                    kcnt_d  = 5'd0;
                end else begin
                    kcnt_d = kcnt_q + 5'd1;
                end
            end else if (csm_req_q && i_CYCLE_31) begin
                keyon_d   = 1'b1;
                kcnt_d    = 5'd0;
                csm_req_d = 1'b0;
            end else if (csm_q && i_TIMERA_OVFL) begin
                csm_req_d = 1'b1;
            end else begin
                csm_req_d = csm_req_q;
            end
        end else begin
            keyon_d = keyon_q;
        end
    end

    // CSM registers
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            csm_req_q <= 1'b0;
            keyon_q   <= 1'b0;
            kcnt_q    <= 5'd0;
        end else begin
            csm_req_q <= csm_req_d;
            keyon_q   <= keyon_d;
            kcnt_q    <= kcnt_d;
        end
    end

    assign o_CSM_KEYON = keyon_q;
`else
    logic unused_s;

    assign unused_s    = &{1'b0, i_phi1_NCEN_n, csm_q, i_TIMERA_OVFL};
    assign o_CSM_KEYON = 1'b0;
`endif

    assign o_CLKA1         = clka1_q;
    assign o_CLKA2         = clka2_q;
    assign o_CLKB          = clkb_q;
    assign o_TIMERA_RUN    = runa_q;
    assign o_TIMERB_RUN    = runb_q;
    assign o_TIMERA_IRQ_EN = irqa_q;
    assign o_TIMERB_IRQ_EN = irqb_q;
    assign o_TIMERA_FRST   = frsta_q;
    assign o_TIMERB_FRST   = frstb_q;
    assign o_BUSY          = busy_q;
    assign o_STATUS        = {busy_q, 5'b00000, i_TIMERB_FLAG, i_TIMERA_FLAG};

endmodule

// File: tb/tb_ika2151_timer_ctrl.sv
// Randomized bench for ika2151_timer_ctrl against a tick-counting reference model.
module tb_ika2151_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_phi1_PCEN_n = 1'b1, i_phi1_NCEN_n = 1'b1, i_CYCLE_31 = 1'b0;
    logic       i_CS_n = 1'b1, i_WR_n = 1'b1, i_A0 = 1'b0;
    logic [7:0] i_D = 8'h00;
    logic       i_TIMERA_FLAG = 1'b0, i_TIMERB_FLAG = 1'b0, i_TIMERA_OVFL = 1'b0;
    logic [7:0] o_CLKA1, o_CLKB, o_STATUS;
    logic [1:0] o_CLKA2;
    logic       o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN;
    logic       o_TIMERA_FRST, o_TIMERB_FRST, o_CSM_KEYON, o_BUSY;

    ika2151_timer_ctrl dut (
        .i_EMUCLK(clk), .i_MRST_n(rst_n),
        .i_phi1_PCEN_n(i_phi1_PCEN_n), .i_phi1_NCEN_n(i_phi1_NCEN_n), .i_CYCLE_31(i_CYCLE_31),
        .i_CS_n(i_CS_n), .i_WR_n(i_WR_n), .i_A0(i_A0), .i_D(i_D),
        .i_TIMERA_FLAG(i_TIMERA_FLAG), .i_TIMERB_FLAG(i_TIMERB_FLAG), .i_TIMERA_OVFL(i_TIMERA_OVFL),
        .o_CLKA1(o_CLKA1), .o_CLKA2(o_CLKA2), .o_CLKB(o_CLKB),
        .o_TIMERA_RUN(o_TIMERA_RUN), .o_TIMERB_RUN(o_TIMERB_RUN),
        .o_TIMERA_IRQ_EN(o_TIMERA_IRQ_EN), .o_TIMERB_IRQ_EN(o_TIMERB_IRQ_EN),
        .o_TIMERA_FRST(o_TIMERA_FRST), .o_TIMERB_FRST(o_TIMERB_FRST),
        .o_CSM_KEYON(o_CSM_KEYON), .o_BUSY(o_BUSY), .o_STATUS(o_STATUS)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int busy_ticks, frsta_ticks, frstb_ticks, keyon_ticks, ticks_seen;
    logic [4:0] slot = 5'd0;

    // Reference model: busy and key-on as remaining-tick countdowns
    bit       m_prev, m_pending, m_csm, m_req;
    int       m_busy_left, m_key_left;
    int       m_addr, m_data, m_clka1, m_clka2, m_clkb;
    bit       m_runa, m_runb, m_irqa, m_irqb, m_frsta, m_frstb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic m_reset();
        m_prev = 0; m_pending = 0; m_csm = 0; m_req = 0;
        m_busy_left = 0; m_key_left = 0;
        m_addr = 0; m_data = 0; m_clka1 = 0; m_clka2 = 0; m_clkb = 0;
        m_runa = 0; m_runb = 0; m_irqa = 0; m_irqb = 0; m_frsta = 0; m_frstb = 0;
    endtask

    task automatic m_step(input bit tick);
        bit strobe, fall, was_busy, commit, csm_old;
        strobe   = i_CS_n | i_WR_n;
        fall     = m_prev && !strobe;
        m_prev   = strobe;
        was_busy = (m_busy_left > 0);
        csm_old  = m_csm;
        commit   = tick && i_CYCLE_31 && m_pending;
`ifdef IKA2151_TIMER_CTRL_CSM_EN
        if (tick) begin
            if (m_key_left > 0) m_key_left--;
            else if (m_req && i_CYCLE_31) begin m_key_left = 32; m_req = 0; end
            else if (csm_old && i_TIMERA_OVFL) m_req = 1;
        end
`endif
        if (tick) begin m_frsta = 0; m_frstb = 0; end
        if (commit) begin
            m_pending = 0;
            if (m_addr == 'h10) m_clka1 = m_data;
            if (m_addr == 'h11) m_clka2 = m_data % 4;
            if (m_addr == 'h12) m_clkb = m_data;
            if (m_addr == 'h14) begin
                m_csm   = (m_data / 128) % 2;
                m_frstb = (m_data / 32) % 2;
                m_frsta = (m_data / 16) % 2;
                m_irqb  = (m_data / 8) % 2;
                m_irqa  = (m_data / 4) % 2;
                m_runb  = (m_data / 2) % 2;
                m_runa  = m_data % 2;
            end
        end
        if (tick && m_busy_left > 0) m_busy_left--;
        if (fall && !i_A0) m_addr = i_D;
        if (fall && i_A0 && !was_busy) begin
            m_data = i_D; m_pending = 1; m_busy_left = 64;
        end
    endtask

    task automatic check_outputs();
        chk("clka1", o_CLKA1, m_clka1);
        chk("clka2", o_CLKA2, m_clka2);
        chk("clkb", o_CLKB, m_clkb);
        chk("ctrl", {o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN},
            {m_runa, m_runb, m_irqa, m_irqb});
        chk("frst", {o_TIMERB_FRST, o_TIMERA_FRST}, {m_frstb, m_frsta});
        chk("busy", o_BUSY, m_busy_left > 0);
        chk("status", o_STATUS, (m_busy_left > 0 ? 128 : 0) + 2 * i_TIMERB_FLAG + i_TIMERA_FLAG);
`ifdef IKA2151_TIMER_CTRL_CSM_EN
        chk("keyon", o_CSM_KEYON, m_key_left > 0);
`else
        chk("keyon", o_CSM_KEYON, 0);
`endif
    endtask

    // One EMUCLK cycle: phi1 enable and slot marker set at negedge, model stepped after posedge
    task automatic cycle();
        bit tick;
        @(negedge clk);
        i_phi1_PCEN_n = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
        i_CYCLE_31    = (slot == 5'd31);
        tick          = !i_phi1_PCEN_n;
        if (tick) begin
            ticks_seen++;
            if (o_BUSY) busy_ticks++;
            if (o_TIMERA_FRST) frsta_ticks++;
            if (o_TIMERB_FRST) frstb_ticks++;
            if (o_CSM_KEYON) keyon_ticks++;
        end
        @(posedge clk);
        #1;
        m_step(tick);
        check_outputs();
        if (tick) slot = slot + 5'd1;
    endtask

    task automatic bus_wr(input logic a0, input logic [7:0] d);
        i_CS_n = 1'b0; i_WR_n = 1'b0; i_A0 = a0; i_D = d;
        cycle();
        cycle();
        i_CS_n = 1'b1; i_WR_n = 1'b1;
        cycle();
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (m_busy_left == 0 && !m_pending) done = 1;
            else cycle();
        end
        if (!done) chk("idle_timeout", 1, 0);
    endtask

    task automatic run_ticks(input int n);
        int start;
        start = ticks_seen;
        for (int i = 0; i < 100 * n && ticks_seen - start < n; i++) cycle();
        if (ticks_seen - start < n) chk("tick_timeout", ticks_seen - start, n);
    endtask

    task automatic clear_counts();
        busy_ticks = 0; frsta_ticks = 0; frstb_ticks = 0; keyon_ticks = 0;
    endtask

    task automatic wait_slot0();
        for (int i = 0; i < 2000 && slot != 5'd0; i++) cycle();
    endtask

    initial begin
        ticks_seen = 0;
        clear_counts();
        m_reset();
        #22;
        chk("rst_outputs", {o_CLKA1, o_CLKA2, o_CLKB, o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN,
            o_TIMERB_IRQ_EN, o_TIMERA_FRST, o_TIMERB_FRST, o_CSM_KEYON, o_BUSY}, 0);
        chk("rst_status", o_STATUS, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle();

        bus_wr(1'b0, 8'h10);
        clear_counts();
        bus_wr(1'b1, 8'hA5);
        chk("busy_status7", o_STATUS[7], 1'b1);
        wait_idle();
        chk("clka1_a5", o_CLKA1, 8'hA5);
        chk("busy_64_ticks", busy_ticks, 64);

        bus_wr(1'b0, 8'h14);
        clear_counts();
        bus_wr(1'b1, 8'h3F);
        wait_idle();
        run_ticks(2);
        chk("ctrl_set", {o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN}, 4'b1111);
        chk("frsta_one_tick", frsta_ticks, 1);
        chk("frstb_one_tick", frstb_ticks, 1);
        clear_counts();
        bus_wr(1'b1, 8'h00);
        wait_idle();
        run_ticks(2);
        chk("ctrl_clr", {o_TIMERA_RUN, o_TIMERB_RUN, o_TIMERA_IRQ_EN, o_TIMERB_IRQ_EN}, 4'b0000);
        chk("frst_none", frsta_ticks + frstb_ticks, 0);

        bus_wr(1'b0, 8'h12);
        clear_counts();
        bus_wr(1'b1, 8'h11);
        for (int i = 0; i < 2000 && busy_ticks < 10; i++) cycle();
        bus_wr(1'b1, 8'h22);
        wait_idle();
        chk("clkb_first_wins", o_CLKB, 8'h11);
        chk("busy_64_ignored_wr", busy_ticks, 64);

        bus_wr(1'b0, 8'h11);
        bus_wr(1'b1, 8'hFF);
        wait_idle();
        chk("clka2_ff", o_CLKA2, 2'b11);
        bus_wr(1'b0, 8'h13);
        clear_counts();
        bus_wr(1'b1, 8'hFF);
        wait_idle();
        chk("busy_64_reg13", busy_ticks, 64);
        chk("reg13_no_effect", {o_CLKA1, o_CLKB, o_CLKA2}, {8'hA5, 8'h11, 2'b11});

        bus_wr(1'b0, 8'h14);
        bus_wr(1'b1, 8'h81);
        wait_idle();
        clear_counts();
        i_TIMERA_OVFL = 1'b1;
        begin
            int t0;
            t0 = ticks_seen;
            for (int i = 0; i < 200 && ticks_seen == t0; i++) cycle();
        end
        i_TIMERA_OVFL = 1'b0;
        run_ticks(80);
`ifdef IKA2151_TIMER_CTRL_CSM_EN
        chk("keyon_32_ticks", keyon_ticks, 32);
`else
        chk("keyon_none", keyon_ticks, 0);
`endif

        wait_slot0();
        bus_wr(1'b0, 8'h10);
        bus_wr(1'b1, 8'h5A);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_drop", o_BUSY, 1'b0);
        chk("rst_clka1", o_CLKA1, 8'h00);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(70);
        chk("no_commit_after_rst", o_CLKA1, 8'h00);

        for (int i = 0; i < 6000; i++) begin
            i_CS_n        = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            i_WR_n        = $urandom_range(0, 1);
            i_A0          = $urandom_range(0, 1);
            if (!i_A0) i_D = ($urandom_range(0, 5) == 5) ? 8'($urandom) : 8'(8'h10 + $urandom_range(0, 4));
            else       i_D = 8'($urandom);
            i_TIMERA_OVFL = ($urandom_range(0, 7) == 0);
            i_TIMERA_FLAG = $urandom_range(0, 1);
            i_TIMERB_FLAG = $urandom_range(0, 1);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
